div_result_reconstructor: RTL



---
 rtl/div_result_reconstructor_if.sv | 23 ++
 rtl/div_result_reconstructor.sv | 86 ++++++++
 2 files changed

// File: rtl/div_result_reconstructor_if.sv
// Operand/result handshake bundle for the dividend reconstructor.
// slave = reconstructor side, master = producer/consumer side.
interface div_result_reconstructor_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  q;
    logic [7:0]  r;
    logic [7:0]  d;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] n;
    logic        busy;

    modport master (
        output in_valid, q, r, d, out_ready,
        input  in_ready, out_valid, n, busy
    );

    modport slave (
        input  in_valid, q, r, d, out_ready,
        output in_ready, out_valid, n, busy
    );
endinterface

// File: rtl/div_result_reconstructor.sv
// Shift-add rebuild of n = q*d + r over 8 cycles.
// APPROX_LOW_COLS_EN: columns 0..5 of the accumulator adder are approximate.
module div_result_reconstructor (
    input  logic                          clk,
    input  logic                          rst_n,
    div_result_reconstructor_if.slave     bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [15:0] acc;
    logic [15:0] mcand;
    logic [7:0]  mplier;
    logic [2:0]  cnt;
    logic [15:0] sum;

`ifdef APPROX_LOW_COLS_EN
    // Low columns: OR for sum, AND for carry; carry into column 6 is column 5's.
    always_comb begin : approx_add
        logic cy;
        cy  = 1'b0;
        sum = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < 6) begin
                sum[i] = acc[i] | mcand[i] | cy;
                cy     = acc[i] & mcand[i];
            end else begin
                sum[i] = acc[i] ^ mcand[i] ^ cy;
                cy     = (acc[i] & mcand[i]) | (cy & (acc[i] ^ mcand[i]));
            end
        end
    end
`else
    assign sum = acc + mcand;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (bus.in_valid) begin
                        acc    <= {8'h00, bus.r};
                        mcand  <= {8'h00, bus.d};
                        mplier <= bus.q;
                        cnt    <= '0;
                        state  <= S_CALC;
                    end
                end
                (state == S_CALC): begin
                    if (mplier[0]) begin
                        acc <= sum;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= S_DONE;
                    end
                end
                (state == S_DONE): begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.busy      = (state == S_CALC);
    assign bus.out_valid = (state == S_DONE);
    assign bus.n         = acc;

endmodule
